// File: rtl/io_switch_port_if.sv
// io_switch_port_if: data-bus side of the 0xfff0 switch input port.
// addr/read from the bus master, io_word back from the port.
interface io_switch_port_if;
  logic [15:0] addr;
  logic        read;
  logic [15:0] io_word;

  modport slave (
    input  addr,
    input  read,
    output io_word
  );

  modport master (
    output addr,
    output read,
    input  io_word
  );
endinterface

// File: rtl/io_switch_port.sv
// io_switch_port: sync + debounce SW0/SW1/PB0, latch PB0 presses, count presses.
// Ports: clock, reset_n, sw0_raw, sw1_raw, pb0_raw, bus (addr/read/io_word), io_sw0, io_sw1.
module io_switch_port #(
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sw0_raw,
  input  logic             sw1_raw,
  input  logic             pb0_raw,
  io_switch_port_if.slave  bus,
  output logic             io_sw0,
  output logic             io_sw1
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  // bit 0 = SW0, bit 1 = SW1, bit 2 = PB0
  logic [2:0]                s1_q;
  logic [2:0]                s2_q;
  logic [2:0]                deb_q;
  logic [2:0]                deb_d;
  logic [2:0][CNT_WIDTH-1:0] cnt_q;
  logic [2:0][CNT_WIDTH-1:0] cnt_d;
  logic                      pb_event_q;
  logic                      pb_event_d;
  logic [7:0]                press_q;
  logic [7:0]                press_d;
  logic                      rise;
  logic                      rd_clr;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign rise   = deb_d[2] & ~deb_q[2];
  assign rd_clr = bus.read && (bus.addr == 16'hfff0);

  // A rise on the clearing edge wins so no press is lost.
  always_comb begin
    pb_event_d = pb_event_q;
    press_d    = press_q;
    if (rise) begin
      pb_event_d = 1'b1;
      press_d    = press_q + 8'd1;
    end else if (rd_clr) begin
      pb_event_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      pb_event_q <= 1'b0;
      press_q    <= '0;
    end else begin
      s1_q       <= {pb0_raw, sw1_raw, sw0_raw};
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      pb_event_q <= pb_event_d;
      press_q    <= press_d;
    end
  end

  assign io_sw0      = deb_q[0];
  assign io_sw1      = deb_q[1];
  assign bus.io_word = {5'd0, press_q, deb_q[1], deb_q[0], pb_event_q};

endmodule

// File: tb/tb_io_switch_port.sv
// tb_io_switch_port: bench for io_switch_port with DEBOUNCE_COUNT=4.
// Table vectors for switch levels plus hand sequences, checked via a timed queue.
module tb_io_switch_port;

  logic clk;
  logic rst_n;
  logic sw0_raw;
  logic sw1_raw;
  logic pb0_raw;
  logic io_sw0;
  logic io_sw1;
  int   cyc;
  int   tests;
  int   fails;

  io_switch_port_if bus ();

  io_switch_port #(
    .DEBOUNCE_COUNT (4),
    .CNT_WIDTH      (16)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .sw0_raw (sw0_raw),
    .sw1_raw (sw1_raw),
    .pb0_raw (pb0_raw),
    .bus     (bus.slave),
    .io_sw0  (io_sw0),
    .io_sw1  (io_sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          due;
    logic [15:0] exp;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic        sw0;
    logic        sw1;
    logic        pb0;
    logic [15:0] pre;
    logic [15:0] post;
  } vec_t;

  vec_t vt[4];

  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               n, act, exp, cyc);
    end
  endtask

  task automatic expect_at(string n, int d, logic [15:0] e);
    sbq.push_back('{n, cyc + d, e});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mid-cycle async reset, then release just after an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_word", bus.io_word, 16'h0000);
    chk("rst_sw0", {15'd0, io_sw0}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: check missed (due %0d, now %0d)",
                 sbq[i].name, sbq[i].due, cyc);
        sbq.delete(i);
      end else if (sbq[i].due == cyc) begin
        chk(sbq[i].name, bus.io_word, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    sw0_raw  = 1'b0;
    sw1_raw  = 1'b0;
    pb0_raw  = 1'b0;
    bus.read = 1'b0;
    bus.addr = 16'h0000;
    rst_n    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("por_word", bus.io_word, 16'h0000);
    chk("por_sw", {14'd0, io_sw1, io_sw0}, 16'h0000);
    tick(2);
    rst_n = 1'b1;

    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002};
    vt[1] = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h0006};
    vt[2] = '{1'b0, 1'b1, 1'b0, 16'h0006, 16'h0004};
    vt[3] = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000};

    for (int v = 0; v < 4; v++) begin
      sw0_raw = vt[v].sw0;
      sw1_raw = vt[v].sw1;
      pb0_raw = vt[v].pb0;
      expect_at($sformatf("vec%0d_pre", v), 5, vt[v].pre);
      expect_at($sformatf("vec%0d_post", v), 6, vt[v].post);
      tick(6);
      @(negedge clk);
      chk($sformatf("vec%0d_sw", v), {14'd0, io_sw1, io_sw0},
          {14'd0, vt[v].sw1, vt[v].sw0});
      tick(1);
    end

    // reset with sw0 held high, then full requalification
    sw0_raw = 1'b1;
    expect_at("sw0_up", 6, 16'h0002);
    tick(8);
    do_reset();
    expect_at("rq_pre", 5, 16'h0000);
    expect_at("rq_post", 6, 16'h0002);
    tick(6);
    sw0_raw = 1'b0;
    expect_at("sw0_down", 6, 16'h0000);
    tick(8);

    // 3-cycle pb glitch rejected
    pb0_raw = 1'b1;
    expect_at("pb_glitch", 8, 16'h0000);
    tick(3);
    pb0_raw = 1'b0;
    tick(8);

    // qualified press, then release
    pb0_raw = 1'b1;
    expect_at("press_pre", 5, 16'h0000);
    expect_at("press_post", 6, 16'h0009);
    tick(6);
    pb0_raw = 1'b0;
    expect_at("release", 8, 16'h0009);
    tick(8);

    // other address does not clear
    bus.read = 1'b1;
    bus.addr = 16'hfff2;
    expect_at("rd_other_in", 0, 16'h0009);
    tick(1);
    bus.read = 1'b0;
    expect_at("rd_other_after", 0, 16'h0009);
    tick(1);

    // read-clear
    bus.read = 1'b1;
    bus.addr = 16'hfff0;
    expect_at("rd_clr_in", 0, 16'h0009);
    tick(1);
    bus.read = 1'b0;
    expect_at("rd_clr_after", 0, 16'h0008);
    tick(1);

    // back-to-back reads stay cleared
    bus.read = 1'b1;
    expect_at("b2b_0", 0, 16'h0008);
    expect_at("b2b_1", 1, 16'h0008);
    expect_at("b2b_2", 2, 16'h0008);
    tick(3);
    bus.read = 1'b0;

    // read-clear edge coincides with D_pb0 rise
    pb0_raw = 1'b1;
    tick(5);
    bus.read = 1'b1;
    expect_at("sim_in", 0, 16'h0008);
    tick(1);
    bus.read = 1'b0;
    expect_at("sim_after", 0, 16'h0011);
    expect_at("sim_hold", 1, 16'h0011);
    tick(2);
    pb0_raw = 1'b0;
    bus.addr = 16'h0000;
    tick(8);

    // independence of sw0/sw1 with interleaved glitches
    do_reset();
    expect_at("ind_5", 5, 16'h0000);
    expect_at("ind_6", 6, 16'h0002);
    expect_at("ind_10", 10, 16'h0002);
    expect_at("ind_13", 13, 16'h0002);
    expect_at("ind_14", 14, 16'h0006);
    expect_at("ind_16", 16, 16'h0006);
    expect_at("ind_19", 19, 16'h0006);
    expect_at("ind_20", 20, 16'h0004);
    sw0_raw = 1'b1;
    tick(2);
    sw1_raw = 1'b1;
    tick(2);
    sw1_raw = 1'b0;
    tick(4);
    sw1_raw = 1'b1;
    tick(1);
    sw0_raw = 1'b0;
    tick(3);
    sw0_raw = 1'b1;
    tick(2);
    sw0_raw = 1'b0;
    tick(6);
    sw1_raw = 1'b0;
    tick(8);

    // 256 presses wrap the count back to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'(i + 1);
      pb0_raw = 1'b1;
      if (i % 64 == 0 || i >= 254)
        expect_at($sformatf("wrap_%0d", i), 6,
                  {5'd0, c, 2'b00, 1'b1});
      tick(6);
      pb0_raw = 1'b0;
      tick(6);
    end
    @(negedge clk);
    chk("wrap_cnt", {8'd0, bus.io_word[10:3]}, 16'h0000);
    chk("wrap_word", bus.io_word, 16'h0001);

    for (int w = 0; w < 50 && sbq.size() != 0; w++)
      @(posedge clk);
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d checks pending", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
